// File: rtl/mc_cu_hs_if.sv
// -----------------------------------------------------------------------------
// mc_cu_hs_if : control bundle between the multi-cycle MIPS control unit and
//               the shared datapath / memory port.
//
// Signals (direction seen from the control unit, modport master):
//   in  op[5:0], func[5:0]   instruction register fields IR[31:26] / IR[5:0]
//   in  z                    ALU zero flag (meaningful in EXE)
//   in  mem_ready            memory completes the current access this cycle
//   out wpc, wir             PC / IR write enables
//   out iord                 memory address select (0=PC, 1=ALUout)
//   out mem_req, wmem        memory request / write
//   out wreg, regrt, m2reg   register file write, dest=rt, writeback from mem
//   out jal                  write PC+4 to r31
//   out sext, shift          sign-extend immediate, ALU A = sa
//   out alusrca              ALU A select (0=PC, 1=rs)
//   out alusrcb[1:0]         ALU B select (00=rt, 01=4, 10=imm, 11=imm<<2)
//   out aluc[3:0]            ALU operation
//   out pcsource[1:0]        next PC (00=ALU, 01=ALUout, 10=rs, 11=jump)
//   out state[2:0]           current FSM state (debug)
//   out bus_err, illegal     sticky timeout / undefined-instruction flags
// -----------------------------------------------------------------------------
interface mc_cu_hs_if;
   logic [5:0] op;
   logic [5:0] func;
   logic       z;
   logic       mem_ready;
   logic       wpc;
   logic       wir;
   logic       iord;
   logic       mem_req;
   logic       wmem;
   logic       wreg;
   logic       regrt;
   logic       m2reg;
   logic       jal;
   logic       sext;
   logic       shift;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [3:0] aluc;
   logic [1:0] pcsource;
   logic [2:0] state;
   logic       bus_err;
   logic       illegal;

   modport master (
      input  op, func, z, mem_ready,
      output wpc, wir, iord, mem_req, wmem, wreg, regrt, m2reg, jal, sext,
             shift, alusrca, alusrcb, aluc, pcsource, state, bus_err, illegal
   );

   modport slave (
      output op, func, z, mem_ready,
      input  wpc, wir, iord, mem_req, wmem, wreg, regrt, m2reg, jal, sext,
             shift, alusrca, alusrcb, aluc, pcsource, state, bus_err, illegal
   );
endinterface

// File: rtl/mc_cu_hs.sv
// -----------------------------------------------------------------------------
// mc_cu_hs : multi-cycle MIPS control unit with ready-handshake memory access.
//
// Sequences the 20-instruction subset (add sub and or xor sll srl sra jr,
// addi andi ori xori lui lw sw beq bne j jal) through IF/ID/EXE/MEM/WB.
// A wait counter bounds the time spent in IF or MEM without mem_ready; on
// expiry the FSM parks in ERR with a sticky bus_err until reset.
//
// Ports:
//   i_clock  system clock, rising edge
//   i_reset  synchronous, active-high reset
//   io_bus   mc_cu_hs_if.master control bundle (see interface header)
//
// Parameters:
//   MEM_TIMEOUT  max consecutive wait cycles in IF/MEM (0 disables timeout)
//   CNT_W        wait counter width
//
// Optional feature macro: MC_CU_ILLEGAL_TRAP_EN
//   defined   : undefined instruction in ID sets sticky illegal, goes to ERR
//   undefined : illegal tied 0, undefined instructions behave as a NOP
// -----------------------------------------------------------------------------
module mc_cu_hs #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1
) (
   input  logic          i_clock,
   input  logic          i_reset,
   mc_cu_hs_if.master    io_bus
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EXE = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4,
      S_ERR = 3'd5
   } state_t;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_AND = 4'b0001;
   localparam logic [3:0] ALU_OR  = 4'b0101;
   localparam logic [3:0] ALU_XOR = 4'b0010;
   localparam logic [3:0] ALU_LUI = 4'b0110;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1111;

   localparam logic [CNT_W-1:0] C_LIMIT =
      CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
   localparam bit C_TO_EN = (MEM_TIMEOUT > 0);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic             r_bus_err;
   logic             w_timeout;

   // ---------------- instruction decode ----------------
   logic [5:0] w_op, w_func;
   assign w_op   = io_bus.op;
   assign w_func = io_bus.func;

   logic w_rtype;
   logic w_add, w_sub, w_and, w_or, w_xor, w_sll, w_srl, w_sra, w_jr;
   logic w_addi, w_andi, w_ori, w_xori, w_lui, w_lw, w_sw;
   logic w_beq, w_bne, w_j, w_jal;
   logic w_r_alu, w_r_shift, w_i_alu, w_undef;

   assign w_rtype = (w_op == 6'b000000);
   assign w_add   = w_rtype & (w_func == 6'b100000);
   assign w_sub   = w_rtype & (w_func == 6'b100010);
   assign w_and   = w_rtype & (w_func == 6'b100100);
   assign w_or    = w_rtype & (w_func == 6'b100101);
   assign w_xor   = w_rtype & (w_func == 6'b100110);
   assign w_sll   = w_rtype & (w_func == 6'b000000);
   assign w_srl   = w_rtype & (w_func == 6'b000010);
   assign w_sra   = w_rtype & (w_func == 6'b000011);
   assign w_jr    = w_rtype & (w_func == 6'b001000);
   assign w_addi  = (w_op == 6'b001000);
   assign w_andi  = (w_op == 6'b001100);
   assign w_ori   = (w_op == 6'b001101);
   assign w_xori  = (w_op == 6'b001110);
   assign w_lui   = (w_op == 6'b001111);
   assign w_lw    = (w_op == 6'b100011);
   assign w_sw    = (w_op == 6'b101011);
   assign w_beq   = (w_op == 6'b000100);
   assign w_bne   = (w_op == 6'b000101);
   assign w_j     = (w_op == 6'b000010);
   assign w_jal   = (w_op == 6'b000011);

   assign w_r_shift = w_sll | w_srl | w_sra;
   assign w_r_alu   = w_add | w_sub | w_and | w_or | w_xor | w_r_shift;
   assign w_i_alu   = w_addi | w_andi | w_ori | w_xori | w_lui;
   assign w_undef   = ~(w_r_alu | w_jr | w_i_alu | w_lw | w_sw |
                        w_beq | w_bne | w_j | w_jal);

   // ALU op for the EXE step: R-type by func, I-type by op, memory ops add.
   logic [3:0] w_aluc_exe;
   always_comb begin
      w_aluc_exe = ALU_ADD;
      if      (w_sub)  w_aluc_exe = ALU_SUB;
      else if (w_and  | w_andi) w_aluc_exe = ALU_AND;
      else if (w_or   | w_ori)  w_aluc_exe = ALU_OR;
      else if (w_xor  | w_xori) w_aluc_exe = ALU_XOR;
      else if (w_lui)  w_aluc_exe = ALU_LUI;
      else if (w_sll)  w_aluc_exe = ALU_SLL;
      else if (w_srl)  w_aluc_exe = ALU_SRL;
      else if (w_sra)  w_aluc_exe = ALU_SRA;
   end

   // Wait limit reached this cycle; mem_ready takes priority where used.
   logic w_limit;
   assign w_limit = C_TO_EN && (r_cnt == C_LIMIT);

`ifdef MC_CU_ILLEGAL_TRAP_EN
   logic r_illegal;
   logic w_trap;
`endif

   // ---------------- next state / outputs ----------------
   logic       w_wpc, w_wir, w_iord, w_mem_req, w_wmem, w_wreg;
   logic       w_regrt, w_m2reg, w_jal_o, w_shift, w_alusrca;
   logic [1:0] w_alusrcb, w_pcsource;
   logic [3:0] w_aluc;

   always_comb begin
      // NOTE: every output gets a default before the case so no path can
      // leave one unassigned and infer a latch.
      w_state_nxt = r_state;
      w_timeout   = 1'b0;
      w_wpc       = 1'b0;
      w_wir       = 1'b0;
      w_iord      = 1'b0;
      w_mem_req   = 1'b0;
      w_wmem      = 1'b0;
      w_wreg      = 1'b0;
      w_regrt     = 1'b0;
      w_m2reg     = 1'b0;
      w_jal_o     = 1'b0;
      w_shift     = 1'b0;
      w_alusrca   = 1'b0;
      w_alusrcb   = 2'b00;
      w_aluc      = ALU_ADD;
      w_pcsource  = 2'b00;
`ifdef MC_CU_ILLEGAL_TRAP_EN
      w_trap      = 1'b0;
`endif
      unique case (r_state)
         S_IF: begin
            w_mem_req = 1'b1;
            w_alusrcb = 2'b01;
            if (io_bus.mem_ready) begin
               w_wir       = 1'b1;
               w_wpc       = 1'b1;
               w_state_nxt = S_ID;
            end else if (w_limit) begin
               w_state_nxt = S_ERR;
               w_timeout   = 1'b1;
            end
         end
         S_ID: begin
            // ALU precomputes the branch target into ALUout.
            w_alusrcb = 2'b11;
            if (w_j) begin
               w_wpc       = 1'b1;
               w_pcsource  = 2'b11;
               w_state_nxt = S_IF;
            end else if (w_jr) begin
               w_wpc       = 1'b1;
               w_pcsource  = 2'b10;
               w_state_nxt = S_IF;
            end else if (w_jal) begin
               w_wpc       = 1'b1;
               w_pcsource  = 2'b11;
               w_wreg      = 1'b1;
               w_jal_o     = 1'b1;
               w_state_nxt = S_IF;
            end else if (w_undef) begin
`ifdef MC_CU_ILLEGAL_TRAP_EN
               w_trap      = 1'b1;
               w_state_nxt = S_ERR;
`else
               w_state_nxt = S_IF;
`endif
            end else begin
               w_state_nxt = S_EXE;
            end
         end
         S_EXE: begin
            w_alusrca = 1'b1;
            if (w_beq | w_bne) begin
               w_aluc      = ALU_SUB;
               w_wpc       = (w_beq & io_bus.z) | (w_bne & ~io_bus.z);
               w_pcsource  = 2'b01;
               w_state_nxt = S_IF;
            end else if (w_rtype) begin
               w_aluc      = w_aluc_exe;
               w_shift     = w_r_shift;
               w_state_nxt = S_WB;
            end else begin
               w_alusrcb   = 2'b10;
               w_aluc      = w_aluc_exe;
               w_state_nxt = (w_lw | w_sw) ? S_MEM : S_WB;
            end
         end
         S_MEM: begin
            w_mem_req = 1'b1;
            w_iord    = 1'b1;
            w_wmem    = w_sw;
            if (io_bus.mem_ready) begin
               w_state_nxt = w_lw ? S_WB : S_IF;
            end else if (w_limit) begin
               w_state_nxt = S_ERR;
               w_timeout   = 1'b1;
            end
         end
         S_WB: begin
            w_wreg      = 1'b1;
            w_regrt     = w_i_alu | w_lw;
            w_m2reg     = w_lw;
            w_state_nxt = S_IF;
         end
         S_ERR: begin
            w_state_nxt = S_ERR;
         end
         default: begin
            w_state_nxt = S_IF;
         end
      endcase

      // No write or request may escape during the reset cycle.
      if (i_reset) begin
         w_wpc     = 1'b0;
         w_wir     = 1'b0;
         w_wmem    = 1'b0;
         w_wreg    = 1'b0;
         w_mem_req = 1'b0;
      end
   end

   // ---------------- registers ----------------
   always_ff @(posedge i_clock) begin
      // NOTE: state is written with non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (i_reset) begin
         r_state   <= S_IF;
         r_cnt     <= '0;
         r_bus_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_bus_err <= r_bus_err | w_timeout;
         if ((w_state_nxt != r_state) || io_bus.mem_ready)
            r_cnt <= '0;
         else if ((r_state == S_IF) || (r_state == S_MEM))
            r_cnt <= r_cnt + CNT_W'(1);
      end
   end

`ifdef MC_CU_ILLEGAL_TRAP_EN
   always_ff @(posedge i_clock) begin
      if (i_reset) r_illegal <= 1'b0;
      else         r_illegal <= r_illegal | w_trap;
   end
   assign io_bus.illegal = r_illegal;
`else
   assign io_bus.illegal = 1'b0;
`endif

   assign io_bus.wpc      = w_wpc;
   assign io_bus.wir      = w_wir;
   assign io_bus.iord     = w_iord;
   assign io_bus.mem_req  = w_mem_req;
   assign io_bus.wmem     = w_wmem;
   assign io_bus.wreg     = w_wreg;
   assign io_bus.regrt    = w_regrt;
   assign io_bus.m2reg    = w_m2reg;
   assign io_bus.jal      = w_jal_o;
   assign io_bus.sext     = w_addi | w_lw | w_sw | w_beq | w_bne;
   assign io_bus.shift    = w_shift;
   assign io_bus.alusrca  = w_alusrca;
   assign io_bus.alusrcb  = w_alusrcb;
   assign io_bus.aluc     = w_aluc;
   assign io_bus.pcsource = w_pcsource;
   assign io_bus.state    = r_state;
   assign io_bus.bus_err  = r_bus_err;

endmodule

// File: tb/tb_mc_cu_hs.sv
// -----------------------------------------------------------------------------
// tb_mc_cu_hs : directed self-checking bench for mc_cu_hs (MEM_TIMEOUT=4).
// Inputs change and outputs are sampled 1 time unit after the falling edge.
// Enable vector en = {wpc, wir, wmem, wreg, mem_req}.
// -----------------------------------------------------------------------------
module tb_mc_cu_hs;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   mc_cu_hs_if bus ();

   mc_cu_hs #(.MEM_TIMEOUT(4)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .io_bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [7:0] en();
      return {3'b000, bus.wpc, bus.wir, bus.wmem, bus.wreg, bus.mem_req};
   endfunction

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.op = 6'd0; bus.func = 6'd0; bus.z = 1'b0; bus.mem_ready = 1'b1;

      // ---- reset: IF state, enables forced off even with mem_ready=1
      tick();
      tick();
      check("rst_state", 8'(bus.state), 8'd0);
      check("rst_en", en(), 8'b00000);
      check("rst_buserr", 8'(bus.bus_err), 8'd0);
      check("rst_illegal", 8'(bus.illegal), 8'd0);
      rst = 1'b0;

      // ---- add: 0,1,2,4,0
      bus.op = 6'b000000; bus.func = 6'b100000;
      #1;
      check("add_if_state", 8'(bus.state), 8'd0);
      check("add_if_en", en(), 8'b11001);
      check("add_if_srcb", 8'(bus.alusrcb), 8'b01);
      tick();
      check("add_id_state", 8'(bus.state), 8'd1);
      check("add_id_en", en(), 8'b00000);
      check("add_id_srcb", 8'(bus.alusrcb), 8'b11);
      tick();
      check("add_exe_state", 8'(bus.state), 8'd2);
      check("add_exe_aluc", 8'(bus.aluc), 8'b0000);
      check("add_exe_srca", 8'(bus.alusrca), 8'd1);
      check("add_exe_srcb", 8'(bus.alusrcb), 8'b00);
      check("add_exe_en", en(), 8'b00000);
      tick();
      check("add_wb_state", 8'(bus.state), 8'd4);
      check("add_wb_en", en(), 8'b00010);
      check("add_wb_regrt", 8'(bus.regrt), 8'd0);
      tick();
      check("add_done_state", 8'(bus.state), 8'd0);

      // ---- lw with 3 wait cycles; ready arrives exactly at the timeout threshold
      bus.op = 6'b100011;
      tick();
      check("lw_id_state", 8'(bus.state), 8'd1);
      check("lw_id_sext", 8'(bus.sext), 8'd1);
      tick();
      check("lw_exe_state", 8'(bus.state), 8'd2);
      check("lw_exe_srcb", 8'(bus.alusrcb), 8'b10);
      check("lw_exe_aluc", 8'(bus.aluc), 8'b0000);
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 3) bus.mem_ready = 1'b1;
         #1;
         check($sformatf("lw_mem%0d_state", i), 8'(bus.state), 8'd3);
         check($sformatf("lw_mem%0d_en", i), en(), 8'b00001);
         check($sformatf("lw_mem%0d_iord", i), 8'(bus.iord), 8'd1);
      end
      tick();
      check("lw_wb_state", 8'(bus.state), 8'd4);
      check("lw_wb_en", en(), 8'b00010);
      check("lw_wb_m2reg", 8'(bus.m2reg), 8'd1);
      check("lw_wb_regrt", 8'(bus.regrt), 8'd1);
      check("lw_buserr", 8'(bus.bus_err), 8'd0);
      tick();
      check("lw_done_state", 8'(bus.state), 8'd0);

      // ---- sw: one MEM cycle, write then back to IF
      bus.op = 6'b101011;
      tick(); tick();
      tick();
      check("sw_mem_state", 8'(bus.state), 8'd3);
      check("sw_mem_en", en(), 8'b00101);
      tick();
      check("sw_done_state", 8'(bus.state), 8'd0);

      // ---- beq taken (z=1), then not taken (z=0)
      bus.op = 6'b000100; bus.z = 1'b1;
      tick(); tick();
      check("beq1_exe_state", 8'(bus.state), 8'd2);
      check("beq1_exe_en", en(), 8'b10000);
      check("beq1_exe_pcsrc", 8'(bus.pcsource), 8'b01);
      check("beq1_exe_aluc", 8'(bus.aluc), 8'b0100);
      tick();
      check("beq1_done_state", 8'(bus.state), 8'd0);
      bus.z = 1'b0;
      tick(); tick();
      check("beq0_exe_state", 8'(bus.state), 8'd2);
      check("beq0_exe_en", en(), 8'b00000);
      tick();
      check("beq0_done_state", 8'(bus.state), 8'd0);

      // ---- bne with z=0 is taken
      bus.op = 6'b000101;
      tick(); tick();
      check("bne_exe_en", en(), 8'b10000);
      tick();

      // ---- sra: shift path
      bus.op = 6'b000000; bus.func = 6'b000011;
      tick(); tick();
      check("sra_exe_aluc", 8'(bus.aluc), 8'b1111);
      check("sra_exe_shift", 8'(bus.shift), 8'd1);
      tick(); tick();

      // ---- ori: I-type writeback to rt
      bus.op = 6'b001101;
      tick(); tick();
      check("ori_exe_aluc", 8'(bus.aluc), 8'b0101);
      check("ori_exe_sext", 8'(bus.sext), 8'd0);
      tick();
      check("ori_wb_regrt", 8'(bus.regrt), 8'd1);
      tick();

      // ---- jal: resolves in ID
      bus.op = 6'b000011;
      tick();
      check("jal_id_state", 8'(bus.state), 8'd1);
      check("jal_id_en", en(), 8'b10010);
      check("jal_id_jal", 8'(bus.jal), 8'd1);
      check("jal_id_pcsrc", 8'(bus.pcsource), 8'b11);
      tick();
      check("jal_done_state", 8'(bus.state), 8'd0);

      // ---- jr
      bus.op = 6'b000000; bus.func = 6'b001000;
      tick();
      check("jr_id_en", en(), 8'b10000);
      check("jr_id_pcsrc", 8'(bus.pcsource), 8'b10);
      tick();
      check("jr_done_state", 8'(bus.state), 8'd0);

      // ---- undefined opcode
      bus.op = 6'b111111;
      tick();
      check("ill_id_state", 8'(bus.state), 8'd1);
      check("ill_id_en", en(), 8'b00000);
      tick();
`ifdef MC_CU_ILLEGAL_TRAP_EN
      check("ill_state", 8'(bus.state), 8'd5);
      check("ill_flag", 8'(bus.illegal), 8'd1);
      check("ill_buserr", 8'(bus.bus_err), 8'd0);
      rst = 1'b1;
      tick();
      check("ill_rst_state", 8'(bus.state), 8'd0);
      check("ill_rst_flag", 8'(bus.illegal), 8'd0);
      rst = 1'b0;
`else
      check("ill_state", 8'(bus.state), 8'd0);
      check("ill_flag", 8'(bus.illegal), 8'd0);
      check("ill_en", en(), 8'b11001);
`endif

      // ---- reset mid-instruction: WB write suppressed in the reset cycle
      bus.op = 6'b000000; bus.func = 6'b100100;
      tick(); tick(); tick();
      check("mid_wb_state", 8'(bus.state), 8'd4);
      rst = 1'b1;
      #1;
      check("mid_rst_en", en(), 8'b00000);
      tick();
      check("mid_rst_state", 8'(bus.state), 8'd0);
      rst = 1'b0;

      // ---- timeout in IF: ERR after 4 waiting cycles
      bus.mem_ready = 1'b0;
      #1;
      check("to_if_en", en(), 8'b00001);
      tick(); tick(); tick();
      check("to_wait3_state", 8'(bus.state), 8'd0);
      check("to_wait3_buserr", 8'(bus.bus_err), 8'd0);
      tick();
      check("to_err_state", 8'(bus.state), 8'd5);
      check("to_err_buserr", 8'(bus.bus_err), 8'd1);
      check("to_err_en", en(), 8'b00000);
      bus.mem_ready = 1'b1;
      tick();
      check("to_err_hold_state", 8'(bus.state), 8'd5);
      check("to_err_hold_buserr", 8'(bus.bus_err), 8'd1);
      rst = 1'b1;
      tick();
      check("to_rst_state", 8'(bus.state), 8'd0);
      check("to_rst_buserr", 8'(bus.bus_err), 8'd0);
      rst = 1'b0;
      tick();
      check("to_restart_state", 8'(bus.state), 8'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mc_cu_hs.md
Name: mc_cu_hs

Overview:
- Multi-cycle MIPS control unit: successor to the single-cycle decoder.
- Decodes the same 20-instruction subset, but sequences each instruction through IF/ID/EXE/MEM/WB states.
- Memory accesses use a ready handshake; a parametrised wait-timeout raises a bus error.
- Sits between the instruction register and the shared multi-cycle datapath (one memory port, PC, IR, ALUout registers).

Parameters:
- MEM_TIMEOUT, 16, max consecutive wait cycles in IF or MEM without mem_ready before the ERR state. 0 disables timeout.
- CNT_W, $clog2(MEM_TIMEOUT+1) (minimum 1), wait counter width.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- op  in  6  IR[31:26]
- func  in  6  IR[5:0]
- z  in  1  ALU zero flag (valid in EXE)
- mem_ready  in  1  memory completes current access this cycle
- wpc  out  1  PC write enable
- wir  out  1  IR write enable
- iord  out  1  memory address select: 0=PC, 1=ALUout
- mem_req  out  1  memory access request
- wmem  out  1  memory write
- wreg  out  1  register file write
- regrt  out  1  destination = rt
- m2reg  out  1  writeback from memory data
- jal  out  1  write PC+4 to r31
- sext  out  1  sign-extend immediate
- shift  out  1  ALU A = sa
- alusrca  out  1  0=PC, 1=rs
- alusrcb  out  2  00=rt, 01=const 4, 10=imm, 11=imm<<2
- aluc  out  4  ALU op
- pcsource  out  2  00=ALU, 01=ALUout (branch), 10=rs (jr), 11=jump target
- state  out  3  current state (debug)
- bus_err  out  1  sticky timeout flag
- illegal  out  1  undefined opcode/func (see option)

Behaviour:
- State encodings: IF=0, ID=1, EXE=2, MEM=3, WB=4, ERR=5.
- Registered: state, wait counter, bus_err. All other outputs are combinational from state/op/func/z.
- Reset: state=IF, counter=0, bus_err=0, illegal=0. While reset=1, wpc/wir/wmem/wreg/mem_req are forced 0.
- aluc encoding: add 0000, sub 0100, and 0001, or 0101, xor 0010, lui 0110, sll 0011, srl 0111, sra 1111.
  - addi/lw/sw use add; andi/ori/xori use and/or/xor; beq/bne use sub.
- sext=1 for addi, lw, sw, beq, bne.
- IF: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluc=add, pcsource=00.
  - On mem_ready: wir=1, wpc=1, go to ID.
  - Otherwise stay and increment counter.
- ID: alusrca=0, alusrcb=11, aluc=add (branch target precompute).
  - j: wpc=1, pcsource=11, go to IF.
  - jr: wpc=1, pcsource=10, go to IF.
  - jal: wpc=1, pcsource=11, wreg=1, jal=1, go to IF.
  - All other instructions go to EXE.
- EXE:
  - R-type: alusrca=1, alusrcb=00, shift=1 for sll/srl/sra.
  - I-type: alusrca=1, alusrcb=10.
  - beq/bne: alusrcb=00, aluc=sub. wpc=(beq&z)|(bne&~z), pcsource=01; go to IF.
  - lw/sw go to MEM; all others go to WB.
- MEM: mem_req=1, iord=1, wmem=sw.
  - On mem_ready: lw goes to WB, sw goes to IF.
  - Otherwise hold all outputs, increment counter.
- WB: wreg=1, regrt=I-type ALU op or lw, m2reg=lw; go to IF.
- Wait counter:
  - Clears on every state change and whenever mem_ready=1.
  - If MEM_TIMEOUT>0 and counter==MEM_TIMEOUT-1 with mem_ready=0: go to ERR and set bus_err=1.
- ERR: all enables 0. Stays in ERR until reset; bus_err stays 1.
- mem_ready outside IF/MEM: ignored.
- mem_ready in the same cycle as the timeout threshold: mem_ready wins (normal transition).
- Reset mid-instruction: state returns to IF on the next edge; no partial write is issued in the reset cycle.

Optional Feature:
- Macro: MC_CU_ILLEGAL_TRAP_EN.
- Defined: in ID, an undefined op (or undefined func when op=0) sets illegal=1 (sticky) and goes to ERR with bus_err unchanged.
- Undefined: illegal is tied 0, and undefined instructions execute as a NOP (ID goes to IF, no writes).

Test Plan:
- add (op=0, func=100000), mem_ready=1 always -> states 0,1,2,4,0; wreg=1 only in WB; aluc=0000; 4 cycles.
- lw (op=100011) with 3 wait cycles in MEM -> states 0,1,2,3,3,3,3,4,0; iord=1 and mem_req=1 throughout MEM; m2reg=1, regrt=1 in WB.
- beq with z=1, then z=0 -> wpc=1 with pcsource=01 in EXE for z=1; wpc=0 for z=0; both return to IF after 3 cycles.
- jal (op=000011) -> in ID: wpc=1, wreg=1, jal=1, pcsource=11; next state IF.
- MEM_TIMEOUT=4, mem_ready held 0 in IF -> ERR after 4 cycles, bus_err=1. Pulse reset -> state=0, bus_err=0.
- With MC_CU_ILLEGAL_TRAP_EN, op=111111 -> illegal=1, state=5. Without the macro -> 0,1,0, no write enables asserted.
